// File: rtl/upower_fetch_unit.sv
// rtl/upower_fetch_unit.sv - uPower instruction-fetch front end with branch redirect and link register
//
// Purpose:
//   Owns the fetch PC and link register, issues one word-addressed request at a
//   time to instruction memory, buffers returned words in a DEPTH-entry
//   first-word-fall-through FIFO and presents {instr, pc} to decode. A taken
//   branch redirects the fetch PC, flushes the buffer and discards any response
//   still in flight.
//
// Ports:
//   clock, reset_n                          clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_ready           fetch request channel (addr = fetch PC)
//   imem_rvalid/imem_rdata                  fetch response channel
//   inst_valid/inst_data/inst_pc/inst_ready decode hand-off (pop on valid & ready)
//   redir_valid/redir_mode/redir_pc         branch redirect, mode 00 abs LI, 01 rel BD,
//   redir_li/redir_bd/redir_lk              10 to LR, 11 rel LI; lk writes LR <= pc+1
//   lr                                      current link register

module upower_fetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 4,
  parameter int              LI_W     = 24,
  parameter int              BD_W     = 14,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redir_valid,
  input  logic [1:0]        redir_mode,
  input  logic [ADDR_W-1:0] redir_pc,
  input  logic [LI_W-1:0]   redir_li,
  input  logic [BD_W-1:0]   redir_bd,
  input  logic              redir_lk,
  output logic [ADDR_W-1:0] lr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,   // nothing outstanding
    S_WAIT,   // one request outstanding, response will be kept
    S_DROP    // one request outstanding, response will be discarded
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;

  logic [DATA_W-1:0] buf_data [DEPTH];
  logic [ADDR_W-1:0] buf_pc   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              accept;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] li_zext;
  logic [ADDR_W-1:0] li_sext;
  logic [ADDR_W-1:0] bd_sext;
  logic [ADDR_W-1:0] target;

  // Branch fields are extended to the PC width, or truncated when wider.
  generate
    if (ADDR_W > LI_W) begin : g_li_ext
      assign li_zext = {{(ADDR_W-LI_W){1'b0}}, redir_li};
      assign li_sext = {{(ADDR_W-LI_W){redir_li[LI_W-1]}}, redir_li};
    end else begin : g_li_trunc
      assign li_zext = redir_li[ADDR_W-1:0];
      assign li_sext = redir_li[ADDR_W-1:0];
    end
    if (ADDR_W > BD_W) begin : g_bd_ext
      assign bd_sext = {{(ADDR_W-BD_W){redir_bd[BD_W-1]}}, redir_bd};
    end else begin : g_bd_trunc
      assign bd_sext = redir_bd[ADDR_W-1:0];
    end
  endgenerate

  assign seq_pc = redir_pc + ADDR_W'(1);

  // Mode 10 reads the old LR, so a linking "branch to LR" jumps to the
  // previous return address while LR picks up the new one.
  always_comb begin
    target = seq_pc + li_sext;
    case (redir_mode)
      2'b00:   target = li_zext;
      2'b01:   target = seq_pc + bd_sext;
      2'b10:   target = lr;
      default: target = seq_pc + li_sext;
    endcase
  end

  // The FIFO slot is reserved at issue: requests go out only from IDLE with a
  // free entry, so the single outstanding response always has room. No request
  // is issued in a redirect cycle or while reset is held.
  assign imem_req  = reset_n && (state == S_IDLE) && (count < CNT_W'(DEPTH)) && !redir_valid;
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;

  // A redirect kills both the response landing this cycle and any pop.
  assign push = (state == S_WAIT) && imem_rvalid && !redir_valid;
  assign pop  = inst_valid && inst_ready && !redir_valid;

  assign inst_valid = (count != '0);
  assign inst_data  = buf_data[rd_ptr];
  assign inst_pc    = buf_pc[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      lr       <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (redir_valid && redir_lk) begin
        lr <= seq_pc;
      end

      if (redir_valid) begin
        fetch_pc <= target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        // An outstanding request must still be drained; if its response is
        // arriving right now it is simply dropped and we are idle again.
        if (state != S_IDLE) begin
          state <= imem_rvalid ? S_IDLE : S_DROP;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              state    <= S_WAIT;
              fetch_pc <= fetch_pc + ADDR_W'(1);
            end
          end
          S_WAIT: begin
            if (imem_rvalid) state <= S_IDLE;
          end
          S_DROP: begin
            if (imem_rvalid) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase

        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (!push && pop) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  // Buffer storage needs no reset; fetch_pc already points one past the
  // outstanding request, hence the -1.
  always_ff @(posedge clock) begin
    if (push) begin
      buf_data[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]   <= fetch_pc - ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_upower_fetch_unit.sv
// tb/tb_upower_fetch_unit.sv - directed self-checking bench for upower_fetch_unit

module tb_upower_fetch_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // 32-bit default instance
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redir_valid;
  logic [1:0]  redir_mode;
  logic [31:0] redir_pc;
  logic [23:0] redir_li;
  logic [13:0] redir_bd;
  logic        redir_lk;
  logic [31:0] lr;

  // 8-bit wrap instance
  logic        reset8_n;
  logic        imem_req8;
  logic [7:0]  imem_addr8;
  logic        imem_ready8;
  logic        imem_rvalid8;
  logic [31:0] imem_rdata8;
  logic        inst_valid8;
  logic [31:0] inst_data8;
  logic [7:0]  inst_pc8;
  logic        inst_ready8;
  logic        redir_valid8;
  logic [1:0]  redir_mode8;
  logic [7:0]  redir_pc8;
  logic [5:0]  redir_li8;
  logic [5:0]  redir_bd8;
  logic        redir_lk8;
  logic [7:0]  lr8;

  upower_fetch_unit dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redir_valid(redir_valid), .redir_mode(redir_mode), .redir_pc(redir_pc),
    .redir_li(redir_li), .redir_bd(redir_bd), .redir_lk(redir_lk), .lr(lr)
  );

  upower_fetch_unit #(.ADDR_W(8), .LI_W(6), .BD_W(6), .RESET_PC(8'hFE)) dut8 (
    .clock(clock), .reset_n(reset8_n),
    .imem_req(imem_req8), .imem_addr(imem_addr8), .imem_ready(imem_ready8),
    .imem_rvalid(imem_rvalid8), .imem_rdata(imem_rdata8),
    .inst_valid(inst_valid8), .inst_data(inst_data8), .inst_pc(inst_pc8), .inst_ready(inst_ready8),
    .redir_valid(redir_valid8), .redir_mode(redir_mode8), .redir_pc(redir_pc8),
    .redir_li(redir_li8), .redir_bd(redir_bd8), .redir_lk(redir_lk8), .lr(lr8)
  );

  int total = 0;
  int bad   = 0;
  bit auto_mem = 1'b1;
  logic [7:0] acc8_q [$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] memf8(input logic [7:0] a);
    return {24'h3C3C3C, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then play a 1-cycle-latency memory.
  task automatic cycle();
    logic        a0;
    logic        a8;
    logic [31:0] ad0;
    logic [7:0]  ad8;
    #1;
    a0  = imem_req && imem_ready;
    ad0 = imem_addr;
    a8  = imem_req8 && imem_ready8;
    ad8 = imem_addr8;
    @(posedge clock);
    #1;
    if (auto_mem) begin
      imem_rvalid = a0;
      imem_rdata  = memf(ad0);
    end
    imem_rvalid8 = a8;
    imem_rdata8  = memf8(ad8);
    if (a8) acc8_q.push_back(ad8);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    #1;
    while (!imem_req && n < 12) begin
      cycle();
      #1;
      n++;
    end
    chk({name, "_req_seen"}, 32'(imem_req), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    #1;
    while (!inst_valid && n < 12) begin
      cycle();
      #1;
      n++;
    end
    chk({name, "_valid_seen"}, 32'(inst_valid), 32'd1);
  endtask

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } fvec_t;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] pc;
    logic [23:0] li;
    logic [13:0] bd;
    logic        lk;
    logic [31:0] tgt;
    logic [31:0] lr;
  } rvec_t;

  fvec_t fv [10];
  rvec_t rv [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_pc;
    int popped;

    // cycle-by-cycle fill from reset with decode stalled
    fv[0] = '{1'b0, 1'b1, 32'd0, 1'b0, 32'd0};
    fv[1] = '{1'b0, 1'b0, 32'd0, 1'b0, 32'd0};
    fv[2] = '{1'b0, 1'b1, 32'd1, 1'b1, 32'd0};
    fv[3] = '{1'b0, 1'b0, 32'd0, 1'b1, 32'd0};
    fv[4] = '{1'b0, 1'b1, 32'd2, 1'b1, 32'd0};
    fv[5] = '{1'b0, 1'b0, 32'd0, 1'b1, 32'd0};
    fv[6] = '{1'b0, 1'b1, 32'd3, 1'b1, 32'd0};
    fv[7] = '{1'b0, 1'b0, 32'd0, 1'b1, 32'd0};
    fv[8] = '{1'b0, 1'b0, 32'd0, 1'b1, 32'd0};
    fv[9] = '{1'b0, 1'b0, 32'd0, 1'b1, 32'd0};

    // redirect targets and resulting LR
    rv[0] = '{2'b01, 32'h0000_0005, 24'h000000, 14'h3FFE, 1'b0, 32'h0000_0004, 32'h0000_0000};
    rv[1] = '{2'b00, 32'h0000_0007, 24'h000040, 14'h0000, 1'b1, 32'h0000_0040, 32'h0000_0008};
    rv[2] = '{2'b10, 32'h0000_0033, 24'h000000, 14'h0000, 1'b0, 32'h0000_0008, 32'h0000_0008};
    rv[3] = '{2'b10, 32'h0000_0100, 24'h000000, 14'h0000, 1'b1, 32'h0000_0008, 32'h0000_0101};
    rv[4] = '{2'b11, 32'h0000_0010, 24'hFFFFFF, 14'h0000, 1'b0, 32'h0000_0010, 32'h0000_0101};
    rv[5] = '{2'b01, 32'h0000_0020, 24'h000000, 14'h1FFF, 1'b0, 32'h0000_2020, 32'h0000_0101};
    rv[6] = '{2'b00, 32'hFFFF_FFFF, 24'hFFFFFF, 14'h0000, 1'b1, 32'h00FF_FFFF, 32'h0000_0000};
    rv[7] = '{2'b11, 32'hFFFF_FFF0, 24'h00000F, 14'h0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
    rv[8] = '{2'b01, 32'h0000_0000, 24'h000000, 14'h2000, 1'b0, 32'hFFFF_E001, 32'h0000_0000};

    reset_n = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    inst_ready = 1'b0; redir_valid = 1'b0; redir_mode = 2'b00; redir_pc = '0;
    redir_li = '0; redir_bd = '0; redir_lk = 1'b0;
    reset8_n = 1'b0; imem_ready8 = 1'b1; imem_rvalid8 = 1'b0; imem_rdata8 = '0;
    inst_ready8 = 1'b1; redir_valid8 = 1'b0; redir_mode8 = 2'b00; redir_pc8 = '0;
    redir_li8 = '0; redir_bd8 = '0; redir_lk8 = 1'b0;

    @(posedge clock);
    #1;
    cycle();
    cycle();
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_lr", lr, 32'd0);
    chk("rst8_lr", 32'(lr8), 32'd0);
    reset_n = 1'b1;

    // fill with decode stalled: requests 0..3 then stop
    for (int c = 0; c < 10; c++) begin
      inst_ready = fv[c].rdy;
      #1;
      chk($sformatf("fill_req%0d", c), 32'(imem_req), 32'(fv[c].req));
      if (fv[c].req) chk($sformatf("fill_addr%0d", c), imem_addr, fv[c].addr);
      chk($sformatf("fill_valid%0d", c), 32'(inst_valid), 32'(fv[c].vld));
      if (fv[c].vld) begin
        chk($sformatf("fill_pc%0d", c), inst_pc, fv[c].pc);
        chk($sformatf("fill_data%0d", c), inst_data, memf(fv[c].pc));
      end
      cycle();
    end

    // streaming: in-order pcs with matching data
    inst_ready = 1'b1;
    exp_pc = 0;
    popped = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (inst_valid) begin
        chk($sformatf("stream_pc%0d", exp_pc), inst_pc, 32'(exp_pc));
        chk($sformatf("stream_data%0d", exp_pc), inst_data, memf(32'(exp_pc)));
        exp_pc++;
        popped++;
      end
      cycle();
    end
    chk("stream_rate", 32'(popped >= 14), 32'd1);

    // redirect table with decode stalled
    inst_ready = 1'b0;
    for (int c = 0; c < 6; c++) cycle();
    #1;
    chk("pre_redir_valid", 32'(inst_valid), 32'd1);
    for (int r = 0; r < 9; r++) begin
      redir_valid = 1'b1;
      redir_mode  = rv[r].mode;
      redir_pc    = rv[r].pc;
      redir_li    = rv[r].li;
      redir_bd    = rv[r].bd;
      redir_lk    = rv[r].lk;
      #1;
      chk($sformatf("redir%0d_req_gated", r), 32'(imem_req), 32'd0);
      cycle();
      redir_valid = 1'b0;
      redir_lk    = 1'b0;
      #1;
      chk($sformatf("redir%0d_flushed", r), 32'(inst_valid), 32'd0);
      chk($sformatf("redir%0d_lr", r), lr, rv[r].lr);
      wait_req($sformatf("redir%0d", r));
      chk($sformatf("redir%0d_addr", r), imem_addr, rv[r].tgt);
      wait_valid($sformatf("redir%0d", r));
      chk($sformatf("redir%0d_head_pc", r), inst_pc, rv[r].tgt);
      chk($sformatf("redir%0d_head_data", r), inst_data, memf(rv[r].tgt));
      cycle();
    end

    // redirect while WAIT; stale 0xDEAD response two cycles later is dropped
    inst_ready = 1'b1;
    wait_req("drop_pre");
    auto_mem = 1'b0;
    imem_rvalid = 1'b0;
    cycle();
    #1;
    chk("drop_wait_req", 32'(imem_req), 32'd0);
    redir_valid = 1'b1;
    redir_mode  = 2'b00;
    redir_li    = 24'h000020;
    redir_lk    = 1'b0;
    cycle();
    redir_valid = 1'b0;
    cycle();
    #1;
    chk("drop_hold_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_DEAD;
    #1;
    chk("drop_late_req", 32'(imem_req), 32'd0);
    cycle();
    imem_rvalid = 1'b0;
    #1;
    chk("drop_after_req", 32'(imem_req), 32'd1);
    chk("drop_after_addr", imem_addr, 32'h0000_0020);
    chk("drop_after_valid", 32'(inst_valid), 32'd0);
    auto_mem = 1'b1;
    wait_valid("drop_fetch");
    chk("drop_head_pc", inst_pc, 32'h0000_0020);
    chk("drop_head_data", inst_data, memf(32'h0000_0020));

    // 8-bit instance: PC wrap, then reset mid-WAIT with a late response
    acc8_q.delete();
    reset8_n = 1'b1;
    for (int c = 0; c < 8; c++) cycle();
    chk("wrap_count", 32'(acc8_q.size() >= 3), 32'd1);
    if (acc8_q.size() >= 3) begin
      chk("wrap_addr0", 32'(acc8_q[0]), 32'h0000_00FE);
      chk("wrap_addr1", 32'(acc8_q[1]), 32'h0000_00FF);
      chk("wrap_addr2", 32'(acc8_q[2]), 32'h0000_0000);
    end
    begin
      int n = 0;
      #1;
      while (!imem_req8 && n < 12) begin
        cycle();
        #1;
        n++;
      end
      chk("rst8_pre_req", 32'(imem_req8), 32'd1);
    end
    cycle();
    #1;
    chk("rst8_in_wait", 32'(imem_req8), 32'd0);
    reset8_n = 1'b0;
    #1;
    chk("rst8_req_low", 32'(imem_req8), 32'd0);
    chk("rst8_valid_low", 32'(inst_valid8), 32'd0);
    #1;
    reset8_n = 1'b1;
    #1;
    chk("rst8_resume_req", 32'(imem_req8), 32'd1);
    chk("rst8_resume_addr", 32'(imem_addr8), 32'h0000_00FE);
    cycle();
    #1;
    chk("rst8_late_ignored", 32'(inst_valid8), 32'd0);
    cycle();
    #1;
    chk("rst8_head_valid", 32'(inst_valid8), 32'd1);
    chk("rst8_head_pc", 32'(inst_pc8), 32'h0000_00FE);
    chk("rst8_head_data", inst_data8, memf8(8'hFE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
